// File: rtl/norm_row_collector.sv
// Packs every `col` consecutive normalized words into one row and queues finished
// rows in a 2-entry FIFO towards the output-memory writer; dropped rows set a sticky flag.
module norm_row_collector #(
   parameter int bw_psum = 11,
   parameter int col     = 8
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [bw_psum-1:0]            psum_norm,
   input  logic                          norm_valid,
   input  logic                          clear,
   output logic [bw_psum*col-1:0]        row_out,
   output logic                          row_valid,
   input  logic                          row_ready,
   output logic [$clog2(col+1)-1:0]      word_cnt,
   output logic                          overflow
);

   localparam int               CW   = $clog2(col + 1);
   localparam int               RW   = bw_psum * col;
   localparam logic [CW-1:0]    LAST = CW'(col - 1);

   // Slots 0..col-2 only; the last word goes straight from the input into the FIFO.
   logic [bw_psum*(col-1)-1:0]  asm_q;
   logic [RW-1:0]               row_d;
   logic [RW-1:0]               mem_q [2];
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [1:0]                  occ_q, occ_d;
   logic                        rd_q, wr_q, ovf_q;
   logic                        take, push, pop, accept;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      take   = norm_valid && !clear;
      push   = take && (cnt_q == LAST);
      pop    = (occ_q != 2'd0) && row_ready;
      accept = push && ((occ_q != 2'd2) || pop);
      row_d  = {psum_norm, asm_q};
      cnt_d  = cnt_q;
      if (clear || push) begin
         cnt_d = '0;
      end else if (take) begin
         cnt_d = cnt_q + CW'(1);
      end
      occ_d = occ_q + {1'b0, accept} - {1'b0, pop};
   end

   // Assembly contents are don't-care after reset or clear, so they carry no reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < col - 1; k++) begin
         if (take && (cnt_q == CW'(k))) begin
            asm_q[k*bw_psum +: bw_psum] <= psum_norm;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: FIFO storage is reset too, so row_out reads zero straight out of reset.
         for (int i = 0; i < 2; i++) begin
            mem_q[i] <= '0;
         end
         cnt_q <= '0;
         occ_q <= '0;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
         ovf_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         cnt_q <= cnt_d;
         occ_q <= occ_d;
         if (accept) begin
            mem_q[wr_q] <= row_d;
            wr_q        <= ~wr_q;
         end
         if (pop) begin
            rd_q <= ~rd_q;
         end
         if (push && !accept) begin
            ovf_q <= 1'b1;
         end
      end
   end

   assign row_out   = mem_q[rd_q];
   assign row_valid = (occ_q != 2'd0);
   assign word_cnt  = cnt_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_norm_row_collector.sv
// Self-checking bench for norm_row_collector: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_norm_row_collector;

   localparam int BW  = 11;
   localparam int COL = 8;
   localparam int RW  = BW * COL;
   localparam int CW  = $clog2(COL + 1);

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [BW-1:0]  psum_norm = '0;
   logic           norm_valid = 1'b0;
   logic           clear = 1'b0;
   logic           row_ready = 1'b0;
   logic [RW-1:0]  row_out;
   logic           row_valid;
   logic [CW-1:0]  word_cnt;
   logic           overflow;

   int checks = 0;
   int errors = 0;

   norm_row_collector #(.bw_psum(BW), .col(COL)) dut (
      .clk        (clk),
      .reset      (reset),
      .psum_norm  (psum_norm),
      .norm_valid (norm_valid),
      .clear      (clear),
      .row_out    (row_out),
      .row_valid  (row_valid),
      .row_ready  (row_ready),
      .word_cnt   (word_cnt),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   // Reference model: a queue of completed rows (capacity 2) and a list of pending words.
   logic [RW-1:0] m_q[$];
   logic [BW-1:0] m_words[COL];
   int            m_cnt = 0;
   bit            m_ovf = 1'b0;
   bit            m_pop, m_push;
   logic [RW-1:0] m_row;

   always @(posedge clk) begin
      if (reset) begin
         m_q.delete();
         m_cnt = 0;
         m_ovf = 1'b0;
      end else begin
         m_pop  = (m_q.size() != 0) && row_ready;
         m_push = 1'b0;
         if (clear) begin
            m_cnt = 0;
         end else if (norm_valid) begin
            m_words[m_cnt] = psum_norm;
            m_cnt++;
            if (m_cnt == COL) begin
               for (int k = 0; k < COL; k++) m_row[k*BW +: BW] = m_words[k];
               m_push = 1'b1;
               m_cnt  = 0;
            end
         end
         if (m_pop) void'(m_q.pop_front());
         if (m_push) begin
            if (m_q.size() < 2) m_q.push_back(m_row);
            else m_ovf = 1'b1;
         end
      end
   end

   function automatic logic [RW-1:0] pack(input logic [BW-1:0] w[COL]);
      logic [RW-1:0] r;
      for (int k = 0; k < COL; k++) r[k*BW +: BW] = w[k];
      return r;
   endfunction

   task automatic step(input logic v, input logic [BW-1:0] d, input logic clr, input logic rdy);
      norm_valid = v;
      psum_norm  = d;
      clear      = clr;
      row_ready  = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      norm_valid = 1'b0;
      clear = 1'b0;
      row_ready = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid: got %0b expected 0", row_valid); end
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL reset_word_cnt: got %0d expected 0", word_cnt); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
      checks++; if (row_out !== '0) begin errors++; $display("FAIL reset_row_out: got %0h expected 0", row_out); end
   endtask

   task automatic test_basic_row();
      logic [BW-1:0] w[COL];
      for (int i = 0; i < COL; i++) begin
         w[i] = BW'(i + 1);
         step(1'b1, w[i], 1'b0, 1'b1);
         if (i < COL - 1) begin
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %0b expected 0 at word %0d", row_valid, i); end
            checks++; if (word_cnt !== CW'(i + 1)) begin errors++; $display("FAIL basic_word_cnt: got %0d expected %0d", word_cnt, i + 1); end
         end
      end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL basic_row_valid: got %0b expected 1", row_valid); end
      checks++; if (row_out !== pack(w)) begin errors++; $display("FAIL basic_row_out: got %0h expected %0h", row_out, pack(w)); end
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL basic_wrap: got %0d expected 0", word_cnt); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %0b expected 0", row_valid); end
   endtask

   task automatic test_gapped();
      logic [BW-1:0] w[COL];
      int n = 0;
      w[0] = 11'h7FF; w[1] = 11'h400; w[2] = 11'h001;
      for (int k = 3; k < COL; k++) w[k] = BW'($urandom);
      for (int c = 0; c < 200 && n < COL; c++) begin
         if ($urandom_range(0, 2) != 0) begin
            step(1'b1, w[n], 1'b0, 1'b1);
            n++;
         end else begin
            step(1'b0, BW'($urandom), 1'b0, 1'b1);
         end
         if (n < COL) begin
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL gapped_early_valid: got %0b expected 0 after %0d words", row_valid, n); end
         end
      end
      checks++; if (n != COL) begin errors++; $display("FAIL gapped_timeout: got %0d words expected %0d", n, COL); end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL gapped_row_valid: got %0b expected 1", row_valid); end
      checks++; if (row_out !== pack(w)) begin errors++; $display("FAIL gapped_row_out: got %0h expected %0h", row_out, pack(w)); end
      step(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_overflow();
      logic [BW-1:0] r0[COL], r1[COL], r2[COL];
      do_reset();
      for (int k = 0; k < COL; k++) begin
         r0[k] = BW'($urandom); r1[k] = BW'($urandom); r2[k] = BW'($urandom);
      end
      for (int k = 0; k < COL; k++) step(1'b1, r0[k], 1'b0, 1'b0);
      for (int k = 0; k < COL; k++) step(1'b1, r1[k], 1'b0, 1'b0);
      for (int k = 0; k < COL; k++) begin
         step(1'b1, r2[k], 1'b0, 1'b0);
         if (k < COL - 1) begin
            checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %0b expected 0 at word %0d", overflow, k); end
         end
      end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %0b expected 1", overflow); end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL ovf_row_valid: got %0b expected 1", row_valid); end
      checks++; if (row_out !== pack(r0)) begin errors++; $display("FAIL ovf_head_row1: got %0h expected %0h", row_out, pack(r0)); end
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL ovf_wrap: got %0d expected 0", word_cnt); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (row_out !== pack(r1)) begin errors++; $display("FAIL ovf_head_row2: got %0h expected %0h", row_out, pack(r1)); end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL ovf_row2_valid: got %0b expected 1", row_valid); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained: got %0b expected 0", row_valid); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
   endtask

   task automatic test_full_simul_pop();
      logic [BW-1:0] r0[COL], r1[COL], r2[COL];
      do_reset();
      for (int k = 0; k < COL; k++) begin
         r0[k] = BW'($urandom); r1[k] = BW'($urandom); r2[k] = BW'($urandom);
      end
      for (int k = 0; k < COL; k++) step(1'b1, r0[k], 1'b0, 1'b0);
      for (int k = 0; k < COL; k++) step(1'b1, r1[k], 1'b0, 1'b0);
      for (int k = 0; k < COL; k++) step(1'b1, r2[k], 1'b0, (k == COL - 1));
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simpop_overflow: got %0b expected 0", overflow); end
      checks++; if (row_out !== pack(r1)) begin errors++; $display("FAIL simpop_row2: got %0h expected %0h", row_out, pack(r1)); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL simpop_row3_valid: got %0b expected 1", row_valid); end
      checks++; if (row_out !== pack(r2)) begin errors++; $display("FAIL simpop_row3: got %0h expected %0h", row_out, pack(r2)); end
      step(1'b0, '0, 1'b0, 1'b1);
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL simpop_drained: got %0b expected 0", row_valid); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simpop_ovf_end: got %0b expected 0", overflow); end
   endtask

   task automatic test_clear();
      logic [BW-1:0] w[COL];
      do_reset();
      for (int k = 0; k < 5; k++) step(1'b1, BW'($urandom), 1'b0, 1'b1);
      checks++; if (word_cnt !== CW'(5)) begin errors++; $display("FAIL clear_pre_cnt: got %0d expected 5", word_cnt); end
      step(1'b1, BW'($urandom), 1'b1, 1'b1);
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL clear_cnt: got %0d expected 0", word_cnt); end
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL clear_no_row: got %0b expected 0", row_valid); end
      for (int k = 0; k < COL; k++) begin
         w[k] = BW'($urandom);
         step(1'b1, w[k], 1'b0, 1'b1);
         if (k < COL - 1) begin
            checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL clear_early_valid: got %0b expected 0 at word %0d", row_valid, k); end
         end
      end
      checks++; if (row_out !== pack(w)) begin errors++; $display("FAIL clear_row: got %0h expected %0h", row_out, pack(w)); end
      step(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      logic [BW-1:0] w[COL];
      do_reset();
      for (int k = 0; k < COL + 3; k++) step(1'b1, BW'($urandom), 1'b0, 1'b0);
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL rstmid_queued: got %0b expected 1", row_valid); end
      checks++; if (word_cnt !== CW'(3)) begin errors++; $display("FAIL rstmid_partial: got %0d expected 3", word_cnt); end
      do_reset();
      checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %0b expected 0", row_valid); end
      checks++; if (word_cnt !== '0) begin errors++; $display("FAIL rstmid_cnt: got %0d expected 0", word_cnt); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf: got %0b expected 0", overflow); end
      for (int k = 0; k < COL; k++) begin
         w[k] = BW'($urandom);
         step(1'b1, w[k], 1'b0, 1'b1);
      end
      checks++; if (row_valid !== 1'b1) begin errors++; $display("FAIL rstmid_row_valid: got %0b expected 1", row_valid); end
      checks++; if (row_out !== pack(w)) begin errors++; $display("FAIL rstmid_row: got %0h expected %0h", row_out, pack(w)); end
      step(1'b0, '0, 1'b0, 1'b1);
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         step(($urandom_range(0, 3) != 0), BW'($urandom), ($urandom_range(0, 31) == 0),
              (c < 300) ? 1'b1 : 1'($urandom_range(0, 1)));
         checks++; if (row_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL b2b_row_valid: got %0b expected %0b cycle %0d", row_valid, (m_q.size() != 0), c); end
         checks++; if (word_cnt !== CW'(m_cnt)) begin errors++; $display("FAIL b2b_word_cnt: got %0d expected %0d cycle %0d", word_cnt, m_cnt, c); end
         checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL b2b_overflow: got %0b expected %0b cycle %0d", overflow, m_ovf, c); end
         if (m_q.size() != 0) begin
            checks++; if (row_out !== m_q[0]) begin errors++; $display("FAIL b2b_row_out: got %0h expected %0h cycle %0d", row_out, m_q[0], c); end
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic_row();
      test_gapped();
      test_overflow();
      test_full_simul_pop();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/norm_row_collector.md
# norm_row_collector

Single-clock receiver that sits downstream of the normalizer on one core's side. It accepts the serial stream of normalized partial sums (`psum_norm`, qualified by `norm_valid`) and packs every `col` consecutive words into one row. Completed rows are queued in a 2-entry FIFO and presented to the output-memory writer over a valid/ready handshake. Overflow is reported through a sticky flag.

## Interface
- `bw_psum`, default 11: width of one normalized word.
- `col`, default 8: words per row; equals the per-core column count.
- `clk`  input  1: clock; all logic is on the rising edge.
- `reset`  input  1: synchronous, active-high reset.
- `psum_norm`  input  `bw_psum`: normalized word, two's complement.
- `norm_valid`  input  1: `psum_norm` is valid this cycle. There is no backpressure; every valid word must be taken or counted as lost.
- `clear`  input  1: discard the partially assembled row. Does not touch the FIFO.
- `row_out`  output  `bw_psum*col`: head-of-FIFO row. Word k occupies bits `[bw_psum*(k+1)-1 : bw_psum*k]`, and word 0 is the first word received.
- `row_valid`  output  1: `row_out` holds a complete row.
- `row_ready`  input  1: the consumer accepts the row when `row_valid && row_ready`.
- `word_cnt`  output  `$clog2(col+1)`: number of words in the partial row.
- `overflow`  output  1: sticky; a completed row was dropped.

## Operation
- Assembly register: `col` words wide, with counter `word_cnt` running 0..col-1.
  - On `norm_valid`, the word is written to slot `word_cnt` and the counter increments.
  - When the word lands in slot col-1, the row is complete. The full row, including that word, is pushed into the FIFO and the counter wraps to 0 in the same edge.
- FIFO: 2 entries, with a read pointer, a write pointer and a 2-bit occupancy count.
  - `row_out` is driven from the head entry.
  - `row_valid` equals (occupancy != 0).
- Push when occupancy == 2 and no pop happens in the same cycle:
  - the row is dropped,
  - `overflow` is set to 1,
  - the counter still wraps to 0.
- Push and pop in the same cycle:
  - Full: legal; the pop frees the slot and the push succeeds.
  - Empty: cannot occur, because pop requires `row_valid`.
  - Occupancy after the cycle = occupancy + push − pop.
- `clear`:
  - sets `word_cnt` to 0; the contents of the assembly register become don't-care.
  - If `clear` and `norm_valid` are both high, `clear` wins and the word is discarded; no push occurs.
- `overflow` clears only on `reset`.
- Arithmetic: words are stored bit-exact. No sign extension, saturation or reordering.
- Reset values:
  - `word_cnt` = 0, `row_valid` = 0, `overflow` = 0.
  - FIFO pointers and occupancy = 0.
  - `row_out` = 0 (FIFO storage is reset).
- Reset mid-row: the partial row and all queued rows are lost, with no flag.

## Timing
- Input to output latency: the last word of a row is sampled at edge N. `row_valid` is high after edge N (visible in cycle N+1) if the FIFO was empty, and `row_out` is stable in that same cycle.
- Throughput: one word per cycle sustained. A new row can complete every `col` cycles.
- A consumer holding `row_ready` high drains one row per cycle.
- While `row_valid && !row_ready`, `row_out` and `row_valid` hold stable.
- `overflow` rises in the cycle after the dropping edge.
- `word_cnt` updates on every edge with `norm_valid` or `clear`.

## Test plan
- **Basic row:** `row_ready`=1, feed words 1..8 on consecutive cycles (`bw_psum`=11, `col`=8) -> one cycle after word 8, `row_valid`=1 with word k = k+1; the row pops the same cycle; `word_cnt` reads 0.
- **Gapped input:** words 0x7FF, 0x400, 0x001, … with random `norm_valid` gaps -> row packed bit-exact in arrival order; `row_valid` never asserts before the 8th valid word.
- **Backpressure and overflow:** `row_ready`=0, stream 24 words -> rows 1 and 2 are queued; row 3 is dropped and `overflow`=1 after its 8th word. Then raise `row_ready` -> rows 1 and 2 come out in order, `row_valid` falls, and `overflow` stays 1.
- **Full with simultaneous pop:** FIFO full; raise `row_ready` exactly on the cycle row 3 completes -> no drop, `overflow` stays 0, and rows 2 and 3 follow.
- **Clear:** after 5 words, assert `clear` together with a valid word -> `word_cnt`=0 and no row is emitted; the next 8 words form a clean row.
- **Reset mid-operation:** 1 row queued plus 3 partial words, then `reset` for 1 cycle -> `row_valid`=0, `word_cnt`=0 and `overflow`=0 the next cycle; the following 8 words produce a correct row.
